// File: rtl/iob_double2ptfloat_pkg.sv
// Shared constants for the double -> pt-float ingress converter: IEEE-754 double
// layout, pt-float width helpers and the input classification type.
package iob_double2ptfloat_pkg;

  localparam int FP_DP_DATA_W = 64;
  localparam int FP_DP_EXP_W  = 11;
  localparam int FP_DP_MAN_W  = 52;
  localparam int FP_DP_BIAS   = 1023;
  localparam int FP_DP_SIG_W  = FP_DP_MAN_W + 1;
  localparam int FP_DP_WEXP_W = FP_DP_EXP_W + 2;

  // Widest exponent a pt-float word can carry for a given exponent-width field.
  function automatic int exp_max_w(input int ew_w);
    return (32'sd1 <<< ew_w) - 32'sd1;
  endfunction

  // Widest mantissa: everything but the exponent-width field.
  function automatic int man_max_w(input int data_w, input int ew_w);
    return data_w - ew_w;
  endfunction

  typedef enum logic [1:0] {
    CLS_NUM  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_cls_t;

endpackage

// File: rtl/iob_ptfloat_round.sv
// Combinational reduction of a 53-bit significand to a MAN_W-1 bit magnitude.
// Rounds to nearest-even when IOB_PTFLOAT_D2P_RND_EN is defined, otherwise truncates.
module iob_ptfloat_round
  import iob_double2ptfloat_pkg::*;
#(
  parameter int MAN_W = 28,
  parameter int EXP_W = FP_DP_WEXP_W
) (
  input  logic [FP_DP_SIG_W-1:0] sig,
  input  logic signed [EXP_W-1:0] exp_raw,
  output logic [MAN_W-2:0]        mag,
  output logic signed [EXP_W-1:0] exp_adj,
  output logic                    carry
);

  localparam int KEEP = MAN_W - 1;
  localparam int DROP = FP_DP_SIG_W - KEEP;
`ifdef IOB_PTFLOAT_D2P_RND_EN
  localparam logic RND_EN = 1'b1;
`else
  localparam logic RND_EN = 1'b0;
`endif

  logic [KEEP-1:0] kept_s;
  logic            guard_s;
  logic            sticky_s;
  logic            up_s;
  logic [KEEP:0]   sum_s;

  // Guard/sticky rounding; a carry out of the top renormalises 10.0 to 01.0.
  always_comb begin
    kept_s   = sig[FP_DP_SIG_W-1 -: KEEP];
    guard_s  = sig[DROP-1];
    sticky_s = |sig[DROP-2:0];
    up_s     = RND_EN & guard_s & (sticky_s | kept_s[0]);
    sum_s    = {1'b0, kept_s} + {{KEEP{1'b0}}, up_s};
    carry    = sum_s[KEEP];
    if (carry) begin
      mag = sum_s[KEEP:1];
    end else begin
      mag = sum_s[KEEP-1:0];
    end
    exp_adj = exp_raw + $signed({{(EXP_W-1){1'b0}}, carry});
  end

endmodule

// File: rtl/iob_double2ptfloat.sv
// IEEE double -> pt-float (exp, man) converter with iterative subnormal normalisation.
// Optional round-to-nearest-even via IOB_PTFLOAT_D2P_RND_EN (truncation otherwise).
module iob_double2ptfloat
  import iob_double2ptfloat_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int EW_W      = 4,
  localparam int EXP_MAX_W = exp_max_w(EW_W),
  localparam int MAN_MAX_W = man_max_w(DATA_W, EW_W)
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic                    cke_i,
  input  logic                    start_i,
  output logic                    done_o,
  input  logic [FP_DP_DATA_W-1:0] fp_i,
  output logic [EXP_MAX_W-1:0]    exp_o,
  output logic [MAN_MAX_W-1:0]    man_o,
  output logic                    ovf_o,
  output logic                    unf_o,
  output logic                    nan_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    RND  = 2'd2,
    PACK = 2'd3
  } state_t;

  localparam int EW = FP_DP_WEXP_W;
  localparam int MW = MAN_MAX_W - 1;
  localparam logic signed [EW-1:0] BIAS_E  = EW'(FP_DP_BIAS);
  localparam logic signed [EW-1:0] SUB_E   = -(EW'(FP_DP_BIAS - 1));
  localparam logic signed [EW-1:0] ONE_E   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]        POW2    = {1'b1, {(MW-1){1'b0}}};
  localparam logic [MAN_MAX_W-1:0] MAN_POS = {1'b0, {(MAN_MAX_W-1){1'b1}}};
  localparam logic [MAN_MAX_W-1:0] MAN_NEG = {1'b1, {(MAN_MAX_W-1){1'b0}}};
  localparam logic [EXP_MAX_W-1:0] EXP_POS = {1'b0, {(EXP_MAX_W-1){1'b1}}};
  localparam int EXP_HI = (32'sd1 <<< (EXP_MAX_W - 1)) - 32'sd1;
  localparam int EXP_LO = -(32'sd1 <<< (EXP_MAX_W - 1));

  state_t                   state_r, state_nxt_s;
  logic [FP_DP_SIG_W-1:0]   sig_r;
  logic signed [EW-1:0]     e_r;
  logic                     s_r;
  fp_cls_t                  cls_r, cls_nxt_s;
  logic [MW-1:0]            rmag_r;
  logic signed [EW-1:0]     re_r;
  logic                     rcarry_r;
  logic [MW-1:0]            mag_s;
  logic signed [EW-1:0]     e_adj_s;
  logic                     carry_s;
  logic [FP_DP_EXP_W-1:0]   e_fld_s;
  logic [FP_DP_MAN_W-1:0]   f_fld_s;
  logic                     sub_s;
  logic [MAN_MAX_W-1:0]     man_sgn_s, man_nxt_s;
  logic signed [EW-1:0]     e_fin_s;
  int                       e_int_s;
  logic [EXP_MAX_W-1:0]     exp_nxt_s;
  logic                     ovf_nxt_s, unf_nxt_s, nan_nxt_s;
  logic                     done_r, ovf_r, unf_r, nan_r;
  logic [EXP_MAX_W-1:0]     exp_r;
  logic [MAN_MAX_W-1:0]     man_r;

  iob_ptfloat_round #(
    .MAN_W(MAN_MAX_W),
    .EXP_W(EW)
  ) u_round (
    .sig    (sig_r),
    .exp_raw(e_r),
    .mag    (mag_s),
    .exp_adj(e_adj_s),
    .carry  (carry_s)
  );

  // Field split and input classification.
  always_comb begin
    e_fld_s = fp_i[FP_DP_DATA_W-2 -: FP_DP_EXP_W];
    f_fld_s = fp_i[FP_DP_MAN_W-1:0];
    sub_s   = (e_fld_s == {FP_DP_EXP_W{1'b0}}) && (f_fld_s != {FP_DP_MAN_W{1'b0}});
    if (e_fld_s == {FP_DP_EXP_W{1'b1}}) begin
      cls_nxt_s = (f_fld_s == {FP_DP_MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
    end else if ((e_fld_s == {FP_DP_EXP_W{1'b0}}) && !sub_s) begin
      cls_nxt_s = CLS_ZERO;
    end else begin
      cls_nxt_s = CLS_NUM;
    end
  end

  // Next-state logic; NORM exits once the value being shifted in lands on bit 52.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_nxt_s = sub_s ? NORM : RND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      NORM: begin
        if (sig_r[FP_DP_SIG_W-2]) begin
          state_nxt_s = RND;
        end else begin
          state_nxt_s = NORM;
        end
      end
      RND:     state_nxt_s = PACK;
      PACK:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sign application and exponent range check on the rounded magnitude.
  always_comb begin
    man_sgn_s = {1'b0, rmag_r};
    e_fin_s   = re_r;
    exp_nxt_s = {EXP_MAX_W{1'b0}};
    man_nxt_s = {MAN_MAX_W{1'b0}};
    ovf_nxt_s = 1'b0;
    unf_nxt_s = 1'b0;
    nan_nxt_s = 1'b0;
    if (s_r) begin
      // -1.0 would be 11.0; re-express as -2.0 * 2^(E-1) to keep MSB != MSB-1.
      if (rcarry_r || (rmag_r == POW2)) begin
        man_sgn_s = MAN_NEG;
        e_fin_s   = re_r - ONE_E;
      end else begin
        man_sgn_s = ~{1'b0, rmag_r} + {{(MAN_MAX_W-1){1'b0}}, 1'b1};
        e_fin_s   = re_r;
      end
    end else begin
      man_sgn_s = {1'b0, rmag_r};
      e_fin_s   = re_r;
    end
    e_int_s = int'(e_fin_s);
    case (cls_r)
      CLS_NUM: begin
        if (e_int_s > EXP_HI) begin
          ovf_nxt_s = 1'b1;
          exp_nxt_s = EXP_POS;
          man_nxt_s = s_r ? MAN_NEG : MAN_POS;
        end else if (e_int_s < EXP_LO) begin
          unf_nxt_s = 1'b1;
        end else begin
          exp_nxt_s = e_int_s[EXP_MAX_W-1:0];
          man_nxt_s = man_sgn_s;
        end
      end
      CLS_INF: begin
        ovf_nxt_s = 1'b1;
        exp_nxt_s = EXP_POS;
        man_nxt_s = s_r ? MAN_NEG : MAN_POS;
      end
      CLS_NAN: nan_nxt_s = 1'b1;
      default: nan_nxt_s = 1'b0;
    endcase
  end

  // State, datapath and output registers; everything freezes while cke_i is low.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r  <= IDLE;
      sig_r    <= {FP_DP_SIG_W{1'b0}};
      e_r      <= {EW{1'b0}};
      s_r      <= 1'b0;
      cls_r    <= CLS_ZERO;
      rmag_r   <= {MW{1'b0}};
      re_r     <= {EW{1'b0}};
      rcarry_r <= 1'b0;
      done_r   <= 1'b0;
      exp_r    <= {EXP_MAX_W{1'b0}};
      man_r    <= {MAN_MAX_W{1'b0}};
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      nan_r    <= 1'b0;
    end else if (cke_i) begin
      state_r <= state_nxt_s;
      done_r  <= (state_r == PACK);
      case (state_r)
        IDLE: begin
          if (start_i) begin
            s_r   <= fp_i[FP_DP_DATA_W-1];
            cls_r <= cls_nxt_s;
            if (e_fld_s == {FP_DP_EXP_W{1'b0}}) begin
              sig_r <= {1'b0, f_fld_s};
              e_r   <= SUB_E;
            end else begin
              sig_r <= {1'b1, f_fld_s};
              e_r   <= $signed({2'b00, e_fld_s}) - BIAS_E;
            end
          end
        end
        NORM: begin
          sig_r <= {sig_r[FP_DP_SIG_W-2:0], 1'b0};
          e_r   <= e_r - ONE_E;
        end
        RND: begin
          rmag_r   <= mag_s;
          re_r     <= e_adj_s;
          rcarry_r <= carry_s;
        end
        PACK: begin
          exp_r <= exp_nxt_s;
          man_r <= man_nxt_s;
          ovf_r <= ovf_nxt_s;
          unf_r <= unf_nxt_s;
          nan_r <= nan_nxt_s;
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign done_o = done_r;
  assign exp_o  = exp_r;
  assign man_o  = man_r;
  assign ovf_o  = ovf_r;
  assign unf_o  = unf_r;
  assign nan_o  = nan_r;

endmodule

// File: tb/tb_iob_double2ptfloat.sv
// Directed vector bench for iob_double2ptfloat (DATA_W=32, EW_W=4 -> 15-bit exp, 28-bit man).
module tb_iob_double2ptfloat;

  localparam int EW = 15;
  localparam int MW = 28;

  logic          clk, arst_n_i, cke_i, start_i, done_o, ovf_o, unf_o, nan_o;
  logic [63:0]   fp_i;
  logic [EW-1:0] exp_o;
  logic [MW-1:0] man_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0]   fp;
    logic [EW-1:0] exp;
    logic [MW-1:0] man;
    logic [2:0]    flg;
    int            lat;
  } vec_t;

  vec_t vt[14];

  iob_double2ptfloat #(.DATA_W(32), .EW_W(4)) dut (
    .clk_i   (clk),
    .arst_n_i(arst_n_i),
    .cke_i   (cke_i),
    .start_i (start_i),
    .done_o  (done_o),
    .fp_i    (fp_i),
    .exp_o   (exp_o),
    .man_o   (man_o),
    .ovf_o   (ovf_o),
    .unf_o   (unf_o),
    .nan_o   (nan_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Called at a negedge: launches a conversion and returns at the negedge where done_o is seen.
  task automatic apply(input logic [63:0] fp, output int lat);
    fp_i    = fp;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, " exp"}, 64'(exp_o), 64'(v.exp));
    chk({nm, " man"}, 64'(man_o), 64'(v.man));
    chk({nm, " flags"}, 64'({ovf_o, unf_o, nan_o}), 64'(v.flg));
  endtask

  initial begin
    int   lat;
    logic saw_done;
    arst_n_i = 1'b0;
    cke_i    = 1'b1;
    start_i  = 1'b0;
    fp_i     = 64'h0;

    vt[0]  = '{64'h3FF0000000000000, 15'h0000, 28'h4000000, 3'b000, 3};
    vt[1]  = '{64'hBFF0000000000000, 15'h7FFF, 28'h8000000, 3'b000, 3};
`ifdef IOB_PTFLOAT_D2P_RND_EN
    vt[2]  = '{64'h3FFFFFFFFFFFFFFF, 15'h0001, 28'h4000000, 3'b000, 3};
    vt[12] = '{64'h3FF0000006000000, 15'h0000, 28'h4000002, 3'b000, 3};
`else
    vt[2]  = '{64'h3FFFFFFFFFFFFFFF, 15'h0000, 28'h7FFFFFF, 3'b000, 3};
    vt[12] = '{64'h3FF0000006000000, 15'h0000, 28'h4000001, 3'b000, 3};
`endif
    vt[3]  = '{64'h0008000000000000, 15'h7C01, 28'h4000000, 3'b000, 4};
    vt[4]  = '{64'h7FF0000000000000, 15'h3FFF, 28'h7FFFFFF, 3'b100, 3};
    vt[5]  = '{64'hFFF0000000000000, 15'h3FFF, 28'h8000000, 3'b100, 3};
    vt[6]  = '{64'h7FF8000000000000, 15'h0000, 28'h0000000, 3'b001, 3};
    vt[7]  = '{64'h4008000000000000, 15'h0001, 28'h6000000, 3'b000, 3};
    vt[8]  = '{64'h0000000000000000, 15'h0000, 28'h0000000, 3'b000, 3};
    vt[9]  = '{64'hC008000000000000, 15'h0001, 28'hA000000, 3'b000, 3};
    vt[10] = '{64'h0000000000000001, 15'h7BCE, 28'h4000000, 3'b000, 55};
    vt[11] = '{64'h3FF0000002000000, 15'h0000, 28'h4000000, 3'b000, 3};
    vt[13] = '{64'h8000000000000000, 15'h0000, 28'h0000000, 3'b000, 3};

    repeat (2) @(negedge clk);
    chk("reset done", 64'(done_o), 64'h0);
    chk_out("reset", '{64'h0, 15'h0, 28'h0, 3'b000, 0});
    arst_n_i = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      apply(vt[i].fp, lat);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vt[i].lat));
      chk_out($sformatf("v%0d", i), vt[i]);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d pulse", i), 64'(done_o), 64'h0);
    end

    // Back-to-back: start while done_o is high.
    apply(64'h3FF0000000000000, lat);
    apply(64'h4008000000000000, lat);
    chk("b2b latency", 64'(lat), 64'd3);
    chk_out("b2b", vt[7]);

    // Stretched done: cke low while done_o is high.
    cke_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("done stretch", 64'(done_o), 64'h1);
    end
    cke_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("done release", 64'(done_o), 64'h0);

    // cke low for 5 cycles while in RND.
    fp_i    = 64'h3FF0000000000000;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    cke_i   = 1'b0;
    lat     = 1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    cke_i = 1'b1;
    while (!done_o && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("cke stall latency", 64'(lat), 64'd8);
    chk_out("cke stall", vt[0]);

    // Asynchronous reset in the middle of a long normalisation.
    @(negedge clk);
    fp_i    = 64'h0000000000000001;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset done", 64'(done_o), 64'h0);
    arst_n_i = 1'b0;
    #1;
    chk("abort done", 64'(done_o), 64'h0);
    chk_out("abort", '{64'h0, 15'h0, 28'h0, 3'b000, 0});
    @(negedge clk);
    arst_n_i = 1'b1;
    saw_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    chk("abort no done", 64'(saw_done), 64'h0);
    apply(vt[9].fp, lat);
    chk("post-abort latency", 64'(lat), 64'd3);
    chk_out("post-abort", vt[9]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
